// File: rtl/pixel_bin2x2.sv
// 2x2 pixel binning: pairs pixels horizontally, stores even-line pair sums in a
// line buffer, and emits the rounded 2x2 mean while the following odd line streams in.
module pixel_bin2x2 #(
  parameter int WIDTH = 2448,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inV,
  input  logic          inH,
  input  logic [DW-1:0] inDATA,
  output logic          outV,
  output logic          outH,
  output logic [DW-1:0] outDATA
);

  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(WIDTH + 1);

  logic          inv_prev_reg;
  logic          sync_open_reg;
  logic          line_reg;
  logic          parity_reg;
  logic [CW-1:0] col_reg;
  logic [DW-1:0] hold_reg;
  logic [DW:0]   rd_data_reg;
  logic          outv_reg;
  logic          outh_reg;
  logic [DW-1:0] outdata_reg;

  logic [DW:0]   linebuf [DEPTH];

  logic          inv_rise;
  logic          gate;
  logic          line_act;
  logic          in_range;
  logic          pix_v;
  logic          pair_v;
  logic [AW-1:0] addr;
  logic [DW:0]   hsum;
  logic [DW+1:0] vsum;

  always_comb begin
    // inv_prev_reg resets high so a frame already running at reset release
    // never looks like a rising edge.
    inv_rise = inV & ~inv_prev_reg;
    gate     = sync_open_reg | inv_rise;
    line_act = inV & inH & gate;
    in_range = col_reg < CW'(WIDTH);
    pix_v    = line_act & in_range;
    pair_v   = pix_v & col_reg[0];
    addr     = AW'(col_reg >> 1);
    hsum     = {1'b0, hold_reg} + {1'b0, inDATA};
    vsum     = {1'b0, hsum} + {1'b0, rd_data_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_prev_reg  <= 1'b1;
      sync_open_reg <= 1'b0;
      line_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      col_reg       <= '0;
      hold_reg      <= '0;
      outv_reg      <= 1'b0;
      outh_reg      <= 1'b0;
      outdata_reg   <= '0;
    end else begin
      inv_prev_reg <= inV;
      line_reg     <= line_act;
      if (inv_rise)
        sync_open_reg <= 1'b1;

      // Column saturates at WIDTH so overlong lines stop touching the buffer.
      if (!line_act)
        col_reg <= '0;
      else if (in_range)
        col_reg <= col_reg + 1'b1;

      if (!inV || inv_rise)
        parity_reg <= 1'b0;
      else if (line_reg && !inH)
        parity_reg <= ~parity_reg;

      if (!line_act)
        hold_reg <= '0;
      else if (pix_v && !col_reg[0])
        hold_reg <= inDATA;

      outv_reg <= inV & gate;
      outh_reg <= pair_v & parity_reg;
      if (pair_v && parity_reg)
        outdata_reg <= DW'((vsum + (DW+2)'(2)) >> 2);
    end
  end

  // Read is issued on the even column so the pair sum is ready on the odd column;
  // writes happen only on even rows and reads are consumed only on odd rows.
  always_ff @(posedge clk) begin
    if (pair_v && !parity_reg)
      linebuf[addr] <= hsum;
    rd_data_reg <= linebuf[addr];
  end

  assign outV    = outv_reg;
  assign outH    = outh_reg;
  assign outDATA = outdata_reg;

endmodule

// File: tb/tb_pixel_bin2x2.sv
// Scoreboard bench for pixel_bin2x2: stimulus tasks push software 2x2 means,
// a monitor pops them on every outH strobe and also tracks outV.
module tb_pixel_bin2x2;
  localparam int W  = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inV = 1'b0;
  logic          inH = 1'b0;
  logic [DW-1:0] inDATA = '0;
  logic          outV;
  logic          outH;
  logic [DW-1:0] outDATA;

  int checks = 0;
  int failures = 0;
  int n_strobes = 0;
  int exp_q[$];
  bit tb_gate = 1'b0;
  int img [0:15][0:15];

  pixel_bin2x2 #(.WIDTH(W), .DW(DW)) dut (
    .clk(clk), .rst(rst), .inV(inV), .inH(inH), .inDATA(inDATA),
    .outV(outV), .outH(outH), .outDATA(outDATA)
  );

  always #5 clk = ~clk;

  // Inputs only change on the falling edge, so inV here is what the DUT sampled.
  always @(posedge clk) begin
    #1;
    checks++;
    if (outV !== (inV & tb_gate)) begin
      failures++;
      $display("FAIL outv_follow: got %b expected %b at %0t", outV, inV & tb_gate, $time);
    end
    if (outH === 1'b1) begin
      n_strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got data %0d expected no strobe at %0t", outDATA, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (outDATA !== DW'(e)) begin
          failures++;
          $display("FAIL strobe_data: got %0d expected %0d at %0t", outDATA, e, $time);
        end else
          $display("strobe %0d data=%0d ok", n_strobes, outDATA);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      inH = 1'b0;
    end
  endtask

  task automatic push_quad(input int r, input int c);
    exp_q.push_back((img[r-1][c-1] + img[r-1][c] + img[r][c-1] + img[r][c] + 2) / 4);
  endtask

  task automatic send_frame(input int w, input int h, input int gap);
    @(negedge clk); inV = 1'b0; inH = 1'b0;
    @(negedge clk); inV = 1'b1; tb_gate = 1'b1;
    for (int r = 0; r < h; r++) begin
      idle(gap);
      for (int c = 0; c < w; c++) begin
        @(negedge clk);
        inH = 1'b1;
        inDATA = DW'(img[r][c]);
        if ((r % 2 == 1) && (c % 2 == 1) && (c < W)) push_quad(r, c);
      end
    end
    @(negedge clk); inH = 1'b0;
    @(negedge clk); inV = 1'b0;
    idle(3);
  endtask

  task automatic check_drain(input string name, input int base, input int want);
    checks++;
    if ((n_strobes - base) != want || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d strobes (%0d pending) expected %0d", name,
               n_strobes - base, exp_q.size(), want);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 3;
    if (outV !== 1'b0) begin failures++; $display("FAIL reset_outv: got %b expected 0", outV); end
    if (outH !== 1'b0) begin failures++; $display("FAIL reset_outh: got %b expected 0", outH); end
    if (outDATA !== '0) begin failures++; $display("FAIL reset_outdata: got %0d expected 0", outDATA); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int base;
    base = n_strobes;
    for (int c = 0; c < 4; c++) begin
      img[0][c] = 4 * c;
      img[1][c] = 4 * c + 4;
    end
    send_frame(4, 2, 2);
    check_drain("basic_4x2", base, 2);
  endtask

  task automatic test_rounding;
    int base;
    int top [8] = '{0, 0, 1, 1, 1, 1, 4095, 4095};
    int bot [8] = '{0, 1, 0, 0, 1, 0, 4095, 4095};
    base = n_strobes;
    for (int c = 0; c < 8; c++) begin
      img[0][c] = top[c];
      img[1][c] = bot[c];
    end
    send_frame(8, 2, 2);
    check_drain("rounding", base, 4);
  endtask

  task automatic test_odd_geometry;
    int base;
    base = n_strobes;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) img[r][c] = 100;
    send_frame(5, 3, 2);
    check_drain("odd_geometry", base, 2);
  endtask

  task automatic test_back_to_back;
    int base;
    base = n_strobes;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) img[r][c] = (c + r * 700) & 4095;
    send_frame(8, 6, 1);
    check_drain("ramp_back_to_back", base, 12);
  endtask

  task automatic test_overlong;
    int base;
    base = n_strobes;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 10; c++) img[r][c] = $urandom_range(4095);
    send_frame(10, 4, 2);
    check_drain("overlong_line", base, 8);
    base = n_strobes;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) img[r][c] = $urandom_range(4095);
    send_frame(8, 4, 1);
    check_drain("after_overlong", base, 8);
  endtask

  task automatic test_reset_mid_frame;
    int base;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) img[r][c] = $urandom_range(1, 4095);
    @(negedge clk); inV = 1'b0; inH = 1'b0;
    @(negedge clk); inV = 1'b1; tb_gate = 1'b1;
    base = n_strobes;
    for (int r = 0; r < 4; r++) begin
      idle(1);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        inH = 1'b1;
        inDATA = DW'(img[r][c]);
        if (r == 2 && c == 0) rst = 1'b0;
        if (tb_gate && (r % 2 == 1) && (c % 2 == 1)) push_quad(r, c);
        if (r == 1 && c == 3) begin
          @(posedge clk);
          #2;
          checks++;
          if (outH !== 1'b1) begin failures++; $display("FAIL pre_reset_strobe: got %b expected 1", outH); end
          rst = 1'b1;
          tb_gate = 1'b0;
          #1;
          checks += 3;
          if (outV !== 1'b0) begin failures++; $display("FAIL async_reset_outv: got %b expected 0", outV); end
          if (outH !== 1'b0) begin failures++; $display("FAIL async_reset_outh: got %b expected 0", outH); end
          if (outDATA !== '0) begin failures++; $display("FAIL async_reset_outdata: got %0d expected 0", outDATA); end
        end
      end
    end
    @(negedge clk); inH = 1'b0;
    @(negedge clk); inV = 1'b0;
    idle(3);
    check_drain("ignored_after_reset", base, 2);
    base = n_strobes;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) img[r][c] = $urandom_range(4095);
    send_frame(8, 4, 2);
    check_drain("frame_after_reset", base, 8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_odd_geometry();
    test_back_to_back();
    test_overlong();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
